// File: rtl/counter_pkg.sv
// Shared types and constants for the counter checker tile.
// Bit positions on the TinyTapeout uio bus live here.
package counter_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10,
    BAD    = 2'b11
  } state_e;

  localparam int VLD_BIT   = 0;
  localparam int CLR_BIT   = 1;
  localparam int SEL_BIT   = 2;

  localparam int LOCK_BIT  = 4;
  localparam int ERR_BIT   = 5;
  localparam int STATE_LSB = 6;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  function automatic logic is_next(
    input logic [7:0] prev,
    input logic [7:0] cur
  );
    return cur == 8'(prev + 8'd1);
  endfunction

endpackage

// File: rtl/counter_if.sv
// Control/status bundle between the checker FSM
// and its saturating error counter.
interface counter_if;
  import counter_pkg::*;

  logic       inc;
  logic       clr;
  logic [7:0] cnt;

  modport master (
    output inc,
    output clr,
    input  cnt
  );

  modport slave (
    input  inc,
    input  clr,
    output cnt
  );

endinterface

// File: rtl/sat_counter8.sv
// 8-bit up-counter, saturating at 255.
// Synchronous clear takes priority over increment.
module sat_counter8
  import counter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  counter_if.slave  bus
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr) begin
      cnt_d = 8'd0;
    end else if (bus.inc && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.cnt = cnt_q;

endmodule

// File: rtl/tt_um_counter_checker.sv
// Receive-side checker for the free-running counter tile:
// captures samples, tracks lock, counts increment errors.
module tt_um_counter_checker
  import counter_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  logic vld;
  logic clr;
  logic sel;

  assign vld = uio_in[VLD_BIT];
  assign clr = uio_in[CLR_BIT];
  assign sel = uio_in[SEL_BIT];

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  logic       cap_vld_q,   cap_vld_d;
  logic [7:0] cap_data_q,  cap_data_d;
  state_e     state_q,     state_d;
  logic [7:0] last_val_q,  last_val_d;
  logic [3:0] good_cnt_q,  good_cnt_d;
  logic [3:0] bad_cnt_q,   bad_cnt_d;
  logic       err_pulse_q, err_pulse_d;
  logic       err_inc;
  logic       match;

  counter_if cnt_bus ();

  assign cnt_bus.inc = err_inc;
  assign cnt_bus.clr = clr;

  sat_counter8 u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cnt_bus.slave)
  );

  assign match = is_next(last_val_q, cap_data_q);

  always_comb begin
    cap_vld_d  = vld;
    cap_data_d = vld ? ui_in : cap_data_q;
  end

  always_comb begin
    state_d     = state_q;
    last_val_d  = last_val_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    case (state_q)
      HUNT: begin
        if (cap_vld_q) begin
          last_val_d = cap_data_q;
          good_cnt_d = 4'd0;
          state_d    = SYNC;
        end
      end
      SYNC: begin
        if (!cap_vld_q) begin
          state_d = HUNT;
        end else begin
          last_val_d = cap_data_q;
          if (match) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_N) begin
              state_d   = LOCKED;
              bad_cnt_d = 4'd0;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        // A gap means upstream was disabled, not that it skipped.
        if (!cap_vld_q) begin
          state_d = HUNT;
        end else begin
          last_val_d = cap_data_q;
          if (match) begin
            bad_cnt_d = 4'd0;
          end else begin
            err_inc     = 1'b1;
            err_pulse_d = 1'b1;
            bad_cnt_d   = bad_cnt_q + 4'd1;
            if (bad_cnt_q + 4'd1 == LOSS_N) begin
              state_d    = SYNC;
              good_cnt_d = 4'd0;
            end
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q   <= 1'b0;
      cap_data_q  <= 8'd0;
      state_q     <= HUNT;
      last_val_q  <= 8'd0;
      good_cnt_q  <= 4'd0;
      bad_cnt_q   <= 4'd0;
      err_pulse_q <= 1'b0;
    end else begin
      cap_vld_q   <= cap_vld_d;
      cap_data_q  <= cap_data_d;
      state_q     <= state_d;
      last_val_q  <= last_val_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    uio_out                     = 8'd0;
    uio_out[LOCK_BIT]           = (state_q == LOCKED);
    uio_out[ERR_BIT]            = err_pulse_q;
    uio_out[STATE_LSB+1:STATE_LSB] = state_q;
  end

  assign uo_out = sel ? last_val_q : cnt_bus.cnt;
  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_counter_checker.sv
// Directed bench for the counter checker tile.
// Second instance uses LOSS_COUNT=15 for saturation.
module tb_tt_um_counter_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic       vld = 1'b0;
  logic       clr = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] uio_in;

  logic [7:0] uo_a, uio_out_a, uio_oe_a;
  logic [7:0] uo_b, uio_out_b, uio_oe_b;

  int n_chk  = 0;
  int n_pass = 0;

  assign uio_in = {5'd0, sel, clr, vld};

  always #5 clk = ~clk;

  tt_um_counter_checker dut (
    .ui_in   (ui_in),
    .uo_out  (uo_a),
    .uio_in  (uio_in),
    .uio_out (uio_out_a),
    .uio_oe  (uio_oe_a),
    .ena     (1'b1),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  tt_um_counter_checker #(
    .LOCK_COUNT (4),
    .LOSS_COUNT (15)
  ) dut15 (
    .ui_in   (ui_in),
    .uo_out  (uo_b),
    .uio_in  (uio_in),
    .uio_out (uio_out_b),
    .uio_oe  (uio_oe_b),
    .ena     (1'b1),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(
    input logic [7:0] b,
    input logic       v,
    input logic       c
  );
    @(negedge clk);
    ui_in = b;
    vld   = v;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld   = 1'b0;
    clr   = 1'b0;
    sel   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    check("rst_uo",     32'(uo_a),      32'd0);
    check("rst_uio",    32'(uio_out_a), 32'd0);
    check("rst_oe",     32'(uio_oe_a),  32'hF0);
    sel = 1'b1;
    #1;
    check("rst_uo_sel", 32'(uo_a),      32'd0);

    // clean lock
    do_reset();
    for (int i = 10; i <= 14; i++) send(8'(i), 1'b1, 1'b0);
    check("lock_early", 32'(uio_out_a[4]), 32'd0);
    send(8'd15, 1'b1, 1'b0);
    check("lock_rise",  32'(uio_out_a[4]),   32'd1);
    check("lock_state", 32'(uio_out_a[7:6]), 32'd2);
    check("lock_err",   32'(uo_a),           32'd0);

    // wrap 255 -> 0
    do_reset();
    for (int i = 249; i <= 254; i++) send(8'(i), 1'b1, 1'b0);
    check("wrap_lock", 32'(uio_out_a[4]), 32'd1);
    for (int i = 255; i <= 258; i++) begin
      send(8'(i), 1'b1, 1'b0);
      check("wrap_pulse", 32'(uio_out_a[5]), 32'd0);
    end
    check("wrap_locked", 32'(uio_out_a[4]), 32'd1);
    check("wrap_err",    32'(uo_a),         32'd0);

    // single glitch
    do_reset();
    for (int i = 16; i <= 21; i++) send(8'(i), 1'b1, 1'b0);
    check("gl_lock", 32'(uio_out_a[4]), 32'd1);
    send(8'd99, 1'b1, 1'b0);
    check("gl_pre",   32'(uio_out_a[5]), 32'd0);
    send(8'd100, 1'b1, 1'b0);
    check("gl_pulse", 32'(uio_out_a[5]), 32'd1);
    check("gl_err",   32'(uo_a),         32'd1);
    check("gl_lkd",   32'(uio_out_a[4]), 32'd1);
    send(8'd101, 1'b1, 1'b0);
    check("gl_post1", 32'(uio_out_a[5]), 32'd0);
    send(8'd102, 1'b1, 1'b0);
    check("gl_post2", 32'(uio_out_a[5]), 32'd0);
    check("gl_err2",  32'(uo_a),         32'd1);
    sel = 1'b1;
    #1;
    check("gl_last",  32'(uo_a),         32'd101);
    sel = 1'b0;

    // loss of lock and relock
    do_reset();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
    send(8'd5, 1'b1, 1'b0);
    check("loss_lock", 32'(uio_out_a[4]), 32'd1);
    send(8'd5, 1'b1, 1'b0);
    check("loss_e1", 32'(uo_a), 32'd1);
    send(8'd5, 1'b1, 1'b0);
    check("loss_e2", 32'(uo_a), 32'd2);
    send(8'd6, 1'b1, 1'b0);
    check("loss_e3",    32'(uo_a),           32'd3);
    check("loss_state", 32'(uio_out_a[7:6]), 32'd1);
    for (int i = 7; i <= 9; i++) send(8'(i), 1'b1, 1'b0);
    check("relock_early", 32'(uio_out_a[4]), 32'd0);
    send(8'd10, 1'b1, 1'b0);
    check("relock", 32'(uio_out_a[4]), 32'd1);

    // gap, then clear colliding with a mismatch
    send(8'd77, 1'b0, 1'b0);
    check("gap_hold", 32'(uio_out_a[7:6]), 32'd2);
    send(8'd11, 1'b1, 1'b0);
    check("gap_hunt",  32'(uio_out_a[7:6]), 32'd0);
    check("gap_err",   32'(uo_a),           32'd3);
    check("gap_pulse", 32'(uio_out_a[5]),   32'd0);
    send(8'd12, 1'b1, 1'b0);
    check("gap_sync",  32'(uio_out_a[7:6]), 32'd1);
    for (int i = 13; i <= 16; i++) send(8'(i), 1'b1, 1'b0);
    check("gap_relock", 32'(uio_out_a[4]), 32'd1);
    send(8'd50, 1'b1, 1'b0);
    check("clr_pre",   32'(uio_out_a[5]), 32'd0);
    send(8'd60, 1'b1, 1'b1);
    check("clr_err",   32'(uo_a),         32'd0);
    check("clr_pulse", 32'(uio_out_a[5]), 32'd1);
    send(8'd61, 1'b1, 1'b0);
    check("clr_resume", 32'(uo_a), 32'd1);

    // saturation on the LOSS_COUNT=15 instance
    do_reset();
    for (int i = 0; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 15; k++) send(8'd200, 1'b1, 1'b0);
      for (int k = 201; k <= 204; k++) send(8'(k), 1'b1, 1'b0);
      if (r == 0) begin
        check("sat_r0_err",   32'(uo_b),           32'd15);
        check("sat_r0_state", 32'(uio_out_b[7:6]), 32'd1);
      end
    end
    check("sat_err", 32'(uo_b), 32'd255);
    sel = 1'b1;
    #1;
    check("sat_last", 32'(uo_b), 32'd203);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_uo_b",  32'(uo_b),      32'd0);
    check("arst_uio_b", 32'(uio_out_b), 32'd0);
    check("arst_uo_a",  32'(uo_a),      32'd0);
    check("arst_uio_a", 32'(uio_out_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tt_um_counter_checker.md
# tt_um_counter_checker

Receive-side companion to the free-running 8-bit counter tile. It samples the counter byte presented on `ui_in` while the upstream enable is high and checks that successive samples increment by exactly one, modulo 256. It acquires and loses lock through a small state machine and keeps a saturating error count. The tile is a TinyTapeout top-level and shares the upstream counter's clock.

## Interface
Parameters:
- `LOCK_COUNT`, default 4: consecutive correct increments required to enter LOCKED (1..15).
- `LOSS_COUNT`, default 3: consecutive mismatches in LOCKED that force a resync (1..15).

Ports:
- `clk`, input, 1: single clock; all logic on posedge. Same clock as the upstream counter.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ui_in`, input, 8: received counter byte.
- `uio_in`, input, 8: [0] `vld`, the upstream enable; sample is present when 1. [1] `clr`, synchronous error-count clear. [2] `sel`, output select. [7:3] unused.
- `uo_out`, output, 8: `sel`=0 gives `err_cnt`; `sel`=1 gives `last_val`.
- `uio_out`, output, 8: [3:0]=0. [4] `locked`. [5] `err_pulse`. [7:6] `state` code.
- `uio_oe`, output, 8: constant 8'hF0.
- `ena`, input, 1: ignored.

## Operation
- Capture stage: every clock, `cap_vld`<=`vld`. When `vld`=1, `cap_data`<=`ui_in`. All checking uses the captured copies.
- States: HUNT=2'b00, SYNC=2'b01, LOCKED=2'b10. Code 2'b11 is unreachable and recovers to HUNT.
- Match rule: `cap_data` == (`last_val`+1) mod 256. The transition 255 -> 0 is a match.
- HUNT:
  - On `cap_vld`: `last_val`<=`cap_data`, `good_cnt`<=0, go to SYNC.
  - Otherwise hold.
- SYNC, on `cap_vld`:
  - Match: `good_cnt`++. Go to LOCKED when `good_cnt`+1 == `LOCK_COUNT`, clearing `bad_cnt`.
  - Mismatch: `good_cnt`<=0 and stay in SYNC. Not counted as an error.
  - `last_val`<=`cap_data` always.
- LOCKED, on `cap_vld`:
  - Match: `bad_cnt`<=0.
  - Mismatch: `err_cnt`++ (saturates at 255), `err_pulse` for 1 cycle, `bad_cnt`++. When `bad_cnt`+1 == `LOSS_COUNT`, go to SYNC with `good_cnt`<=0.
  - `last_val`<=`cap_data` always.
- Gap: `cap_vld`=0 while in SYNC or LOCKED returns to HUNT.
  - Upstream keeps counting while its output is disabled, so a gap is never an error.
  - `err_cnt` and `last_val` are retained across the gap.
- `clr`=1: `err_cnt`<=0 on the next edge. If a mismatch lands on the same edge, `clr` wins and the count stays 0, but `err_pulse` still asserts.
- `locked` = (`state`==LOCKED).

## Timing
- Reset values: `state`=HUNT, `cap_vld`=0, `cap_data`=0, `last_val`=0, `good_cnt`=0, `bad_cnt`=0, `err_cnt`=0, `err_pulse`=0. Resulting outputs: `uo_out`=0, `uio_out`=0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first sample after release enters HUNT.
- Latency: a byte on `ui_in` before edge N is captured at edge N and evaluated at edge N+1.
  - `err_pulse`, `locked` and `err_cnt` update at edge N+1.
  - `uo_out` with `sel`=1 shows the byte after edge N+1.
- Lock time: the first valid sample seeds `last_val`. `locked` rises at the evaluation edge of the `LOCK_COUNT`-th consecutive match, which is sample `LOCK_COUNT`+1.
- `sel` is combinational to `uo_out`.
- `err_pulse` is registered and never wider than 1 cycle per mismatching sample.

## Structure
- Package `counter_pkg` holds:
  - the state enum and codes;
  - the `uio_in` bit indices (`VLD_BIT`=0, `CLR_BIT`=1, `SEL_BIT`=2);
  - the `uio_out` indices (`LOCK_BIT`=4, `ERR_BIT`=5, `STATE_LSB`=6);
  - `UIO_OE_VAL`=8'hF0.
- One sub-module, `sat_counter8`: 8-bit up-counter with `inc` and synchronous `clr`, saturating at 255, `clr` priority. Used for `err_cnt`.
- The FSM and the capture stage stay in the top-level.

## Test plan
- Clean lock: after reset, `vld`=1 with bytes 10,11,12,13,14. `locked` rises at the evaluation edge of byte 14 (`LOCK_COUNT`=4). `state`=2'b10, `err_cnt`=0.
- Wrap: locked, then feed 254,255,0,1. Stays LOCKED, no `err_pulse`, `err_cnt`=0.
- Single glitch: locked at 20, then feed 21,99,100,101. `err_pulse` goes high once, on the evaluation edge of 99. `err_cnt`=1, still LOCKED; 100 and 101 match.
- Loss of lock: locked, then 3 non-incrementing bytes (5,5,5). `err_cnt`=3, `state`=SYNC after the third. Next 4 increments (6,7,8,9) relock.
- Gap and clear: locked, drop `vld` for 1 cycle. `state`=HUNT, `err_cnt` unchanged, no pulse. Then pulse `clr` on the same edge as a LOCKED mismatch: `err_cnt`=0, `err_pulse`=1.
- Saturation and reset: force 300 LOCKED mismatches with `LOSS_COUNT`=15, resyncing as needed. `err_cnt`=255 with `sel`=0. Assert `rst_n`=0 mid-stream: `uo_out` and `uio_out` are 0 immediately, without waiting for a clock edge.
